// File: rtl/domain_seq_pkg.sv
// ============================================================================
//  Module      : domain_seq_pkg
//  Description : Shared types, defaults and helpers for the domain sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package domain_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOCK_WAIT  = 3'd1,
        ST_CLK_ON     = 3'd2,
        ST_RST_ASSERT = 3'd3,
        ST_CLK_OFF    = 3'd4
    } domain_seq_state_e;

    localparam int unsigned DEF_NUM_DOMAINS = 4;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_EN_DLY      = 4;
    localparam int unsigned DEF_RST_DLY     = 4;
    localparam int unsigned DEF_LOCK_TMO    = 200;

    // Width of a domain index; a single domain still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/domain_seq_timer.sv
// ============================================================================
//  Module      : domain_seq_timer
//  Description : Loadable down-counter that saturates at zero, with zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module domain_seq_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/domain_seq_ctrl.sv
// ============================================================================
//  Module      : domain_seq_ctrl
//  Description : Serial power-up/power-down sequencer for clock domains.
//                Optional lock timeout: DOMAIN_SEQ_LOCK_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module domain_seq_ctrl
    import domain_seq_pkg::*;
#(
    parameter int unsigned             NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int unsigned             CNT_W       = DEF_CNT_W,
    parameter logic [NUM_DOMAINS-1:0]  HAS_PLL     = NUM_DOMAINS'(4'b0111),
    parameter int unsigned             EN_DLY      = DEF_EN_DLY,
    parameter int unsigned             RST_DLY     = DEF_RST_DLY,
    parameter int unsigned             LOCK_TMO    = DEF_LOCK_TMO
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic [NUM_DOMAINS-1:0] en_req_i,
    input  logic [NUM_DOMAINS-1:0] pll_locked_i,
    output logic [NUM_DOMAINS-1:0] clk_en_o,
    output logic [NUM_DOMAINS-1:0] rst_no,
    output logic [NUM_DOMAINS-1:0] on_o,
    output logic [NUM_DOMAINS-1:0] err_o,
    output logic                   busy_o
);

    localparam int unsigned IW = idx_width(NUM_DOMAINS);

    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16) begin : g_chk_num
        $error("domain_seq_ctrl: NUM_DOMAINS out of range");
    end
    if (EN_DLY < 1 || EN_DLY >= (64'd1 << CNT_W)) begin : g_chk_en
        $error("domain_seq_ctrl: EN_DLY does not fit CNT_W");
    end
    if (RST_DLY < 1 || RST_DLY >= (64'd1 << CNT_W)) begin : g_chk_rst
        $error("domain_seq_ctrl: RST_DLY does not fit CNT_W");
    end
    if (LOCK_TMO >= (64'd1 << CNT_W)) begin : g_chk_tmo
        $error("domain_seq_ctrl: LOCK_TMO does not fit CNT_W");
    end

    // Delay states last exactly N cycles, so the counter starts one short.
    localparam logic [CNT_W-1:0] c_en_load  = CNT_W'(EN_DLY - 1);
    localparam logic [CNT_W-1:0] c_rst_load = CNT_W'(RST_DLY - 1);
    localparam logic [CNT_W-1:0] c_tmo_load = CNT_W'(LOCK_TMO);

    domain_seq_state_e      state_q;
    logic [IW-1:0]          idx_q;
    logic [NUM_DOMAINS-1:0] clk_en_q, rst_n_q, on_q, err_vec;
    logic                   busy_q;

    logic                   cand_vld;
    logic [IW-1:0]          cand_idx;
    logic                   tmr_load;
    logic [CNT_W-1:0]       tmr_val;
    logic                   tmr_zero;

`ifdef DOMAIN_SEQ_LOCK_TIMEOUT_EN
    logic [NUM_DOMAINS-1:0] err_q, err_set;

    always_comb begin
        err_set = '0;
        if (state_q == ST_LOCK_WAIT && !pll_locked_i[idx_q] && tmr_zero) begin
            err_set[idx_q] = 1'b1;
        end
    end

    assign err_vec = err_q;
`else
    assign err_vec = '0;
`endif

    // Lowest mismatching domain wins; a failed domain still requested is skipped.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
            if (!cand_vld && (en_req_i[i] != on_q[i]) && !(err_vec[i] && en_req_i[i])) begin
                cand_vld = 1'b1;
                cand_idx = IW'(i);
            end
        end
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = c_en_load;
        case (state_q)
            ST_IDLE: begin
                if (cand_vld) begin
                    tmr_load = 1'b1;
                    if (!en_req_i[cand_idx]) begin
                        tmr_val = c_rst_load;
                    end else if (HAS_PLL[cand_idx]) begin
                        tmr_val = c_tmo_load;
                    end
                end
            end
            ST_LOCK_WAIT: tmr_load = pll_locked_i[idx_q];
            default:      tmr_load = 1'b0;
        endcase
    end

    domain_seq_timer #(
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            clk_en_q <= '0;
            rst_n_q  <= '0;
            on_q     <= '0;
            busy_q   <= 1'b0;
`ifdef DOMAIN_SEQ_LOCK_TIMEOUT_EN
            err_q    <= '0;
`endif
        end else begin
`ifdef DOMAIN_SEQ_LOCK_TIMEOUT_EN
            err_q <= (err_q | err_set) & en_req_i;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (cand_vld) begin
                        idx_q  <= cand_idx;
                        busy_q <= 1'b1;
                        if (en_req_i[cand_idx]) begin
                            if (HAS_PLL[cand_idx]) begin
                                state_q <= ST_LOCK_WAIT;
                            end else begin
                                state_q            <= ST_CLK_ON;
                                clk_en_q[cand_idx] <= 1'b1;
                            end
                        end else begin
                            state_q           <= ST_RST_ASSERT;
                            rst_n_q[cand_idx] <= 1'b0;
                            on_q[cand_idx]    <= 1'b0;
                        end
                    end
                end
                ST_LOCK_WAIT: begin
                    if (pll_locked_i[idx_q]) begin
                        state_q         <= ST_CLK_ON;
                        clk_en_q[idx_q] <= 1'b1;
                    end
`ifdef DOMAIN_SEQ_LOCK_TIMEOUT_EN
                    else if (tmr_zero) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
`endif
                end
                ST_CLK_ON: begin
                    if (tmr_zero) begin
                        rst_n_q[idx_q] <= 1'b1;
                        on_q[idx_q]    <= 1'b1;
                        state_q        <= ST_IDLE;
                        busy_q         <= 1'b0;
                    end
                end
                ST_RST_ASSERT: begin
                    if (tmr_zero) begin
                        state_q <= ST_CLK_OFF;
                    end
                end
                ST_CLK_OFF: begin
                    clk_en_q[idx_q] <= 1'b0;
                    state_q         <= ST_IDLE;
                    busy_q          <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_en_o = clk_en_q;
    assign rst_no   = rst_n_q;
    assign on_o     = on_q;
    assign err_o    = err_vec;
    assign busy_o   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_domain_seq_ctrl.sv
// ============================================================================
//  Module      : tb_domain_seq_ctrl
//  Description : Directed bench for domain_seq_ctrl (4 domains, default delays).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_domain_seq_ctrl;

    logic       clk_i = 1'b0;
    logic       arst_i;
    logic [3:0] en_req_i;
    logic [3:0] pll_locked_i;
    logic [3:0] clk_en_o, rst_no, on_o, err_o;
    logic       busy_o;

    int n_vec = 0;
    int n_err = 0;

    domain_seq_ctrl #(
        .NUM_DOMAINS  (4),
        .CNT_W        (8),
        .HAS_PLL      (4'b0111),
        .EN_DLY       (4),
        .RST_DLY      (4),
        .LOCK_TMO     (200)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .en_req_i     (en_req_i),
        .pll_locked_i (pll_locked_i),
        .clk_en_o     (clk_en_o),
        .rst_no       (rst_no),
        .on_o         (on_o),
        .err_o        (err_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        arst_i       = 1'b1;
        en_req_i     = 4'b0000;
        pll_locked_i = 4'b0011;
        tick(2);
        chk("rst_clk_en", clk_en_o, 4'b0000);
        chk("rst_rst_n",  rst_no,   4'b0000);
        chk("rst_on",     on_o,     4'b0000);
        chk("rst_err",    err_o,    4'b0000);
        chk("rst_busy",   {3'b0, busy_o}, 4'b0000);
        arst_i = 1'b0;
        tick(2);

        // Domain 3, no PLL
        en_req_i = 4'b1000;
        tick(1);
        chk("d3_clk_en_n1", clk_en_o, 4'b1000);
        chk("d3_rst_n_n1",  rst_no,   4'b0000);
        chk("d3_busy_n1",   {3'b0, busy_o}, 4'b0001);
        tick(3);
        chk("d3_on_n4",     on_o,     4'b0000);
        chk("d3_busy_n4",   {3'b0, busy_o}, 4'b0001);
        tick(1);
        chk("d3_rst_n_n5",  rst_no,   4'b1000);
        chk("d3_on_n5",     on_o,     4'b1000);
        tick(1);
        chk("d3_busy_n6",   {3'b0, busy_o}, 4'b0000);

        // Domains 0 and 1 together, PLLs locked
        en_req_i = 4'b1011;
        tick(1);
        chk("d01_clk_en_p1", clk_en_o, 4'b1000);
        tick(1);
        chk("d01_clk_en_p2", clk_en_o, 4'b1001);
        tick(3);
        chk("d01_on_p5",     on_o,     4'b1000);
        tick(1);
        chk("d01_on_p6",     on_o,     4'b1001);
        chk("d01_clk_en_p6", clk_en_o, 4'b1001);
        tick(1);
        chk("d01_clk_en_p7", clk_en_o, 4'b1001);
        tick(1);
        chk("d01_clk_en_p8", clk_en_o, 4'b1011);
        tick(4);
        chk("d01_on_p12",    on_o,     4'b1011);
        chk("d01_rst_n_p12", rst_no,   4'b1011);
        tick(1);
        chk("d01_busy_p13",  {3'b0, busy_o}, 4'b0000);

        // Power-down domain 0
        en_req_i = 4'b1010;
        tick(1);
        chk("d0off_rst_n_n1",  rst_no,   4'b1010);
        chk("d0off_on_n1",     on_o,     4'b1010);
        chk("d0off_clk_en_n1", clk_en_o, 4'b1011);
        tick(4);
        chk("d0off_clk_en_n5", clk_en_o, 4'b1011);
        tick(1);
        chk("d0off_clk_en_n6", clk_en_o, 4'b1010);
        tick(1);
        chk("d0off_busy_n7",   {3'b0, busy_o}, 4'b0000);

        // Domain 2 requested, its PLL never locks
        en_req_i = 4'b1110;
        tick(201);
        chk("tmo_err_200",    err_o,    4'b0000);
        chk("tmo_clk_en_200", clk_en_o, 4'b1010);
        chk("tmo_busy_200",   {3'b0, busy_o}, 4'b0001);
        tick(1);
`ifdef DOMAIN_SEQ_LOCK_TIMEOUT_EN
        chk("tmo_err_201",    err_o,    4'b0100);
        chk("tmo_busy_201",   {3'b0, busy_o}, 4'b0000);
        tick(5);
        chk("tmo_err_hold",   err_o,    4'b0100);
        chk("tmo_no_retry",   clk_en_o, 4'b1010);
        chk("tmo_idle_hold",  {3'b0, busy_o}, 4'b0000);
        en_req_i = 4'b1010;
        tick(1);
        chk("tmo_err_clear",  err_o,    4'b0000);
        pll_locked_i = 4'b0111;
        en_req_i     = 4'b1110;
        tick(2);
`else
        chk("wait_err_tied",  err_o,    4'b0000);
        chk("wait_busy",      {3'b0, busy_o}, 4'b0001);
        chk("wait_clk_en",    clk_en_o, 4'b1010);
        pll_locked_i = 4'b0111;
        tick(1);
`endif
        chk("d2_clk_en_up",   clk_en_o, 4'b1110);

        // Asynchronous reset in the middle of domain 2's clock-on delay
        tick(1);
        arst_i = 1'b1;
        #1;
        chk("arst_clk_en", clk_en_o, 4'b0000);
        chk("arst_rst_n",  rst_no,   4'b0000);
        chk("arst_on",     on_o,     4'b0000);
        chk("arst_busy",   {3'b0, busy_o}, 4'b0000);
        arst_i = 1'b0;
        tick(2);
        chk("rescan_clk_en_2",  clk_en_o, 4'b0010);
        tick(4);
        chk("rescan_on_6",      on_o,     4'b0010);
        tick(6);
        chk("rescan_on_12",     on_o,     4'b0110);
        tick(5);
        chk("rescan_on_17",     on_o,     4'b1110);
        chk("rescan_rst_n_17",  rst_no,   4'b1110);
        chk("rescan_clk_en_17", clk_en_o, 4'b1110);
        tick(1);
        chk("rescan_busy_18",   {3'b0, busy_o}, 4'b0000);

        // Short request pulse on domain 0 while domain 3 powers down
        en_req_i = 4'b0110;
        tick(1);
        en_req_i = 4'b0111;
        tick(2);
        en_req_i = 4'b0110;
        tick(3);
        chk("pulse_clk_en_n6", clk_en_o, 4'b0110);
        chk("pulse_busy_n6",   {3'b0, busy_o}, 4'b0000);
        tick(2);
        chk("pulse_clk_en_n8", clk_en_o, 4'b0110);
        chk("pulse_on_n8",     on_o,     4'b0110);
        chk("pulse_busy_n8",   {3'b0, busy_o}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
